// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter owning the select line of a
// shared 2:1 word mux in front of a single valid/ready sink. Requesters take
// turns; an owner keeps the grant for at most MAX_HOLD accepted beats while
// the other side is waiting, and hands over with no idle bubble in that case.
module mux_arbiter #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    // Beat counter wide enough to hold 0..MAX_HOLD.
    localparam int CW = $clog2(MAX_HOLD + 1);

    // Counter value seen on the last beat a grant may take while contended.
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            sel_r;
    logic            sel_s;
    logic            last_r;       // 0 = A was granted last, 1 = B
    logic            last_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_s;

    // Grant-entry request produced by the decode below; applied in one place
    // so that entering a grant always loads sel/last/count consistently.
    logic            enter_s;
    logic            enter_b_s;    // side being granted: 0 = A, 1 = B

    logic            out_valid_s;
    logic            a_ready_s;
    logic            b_ready_s;

    // State, select, last-winner and beat-count registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            sel_r   <= 1'b0;
            last_r  <= 1'b1;       // pretend B went last so A wins the first tie
            count_r <= '0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
            last_r  <= last_s;
            count_r <= count_s;
        end
    end

    // Next-state decode and handshake outputs for the current owner.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        last_s      = last_r;
        count_s     = count_r;
        enter_s     = 1'b0;
        enter_b_s   = 1'b0;
        out_valid_s = 1'b0;
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (a_valid && b_valid) begin
                    // Tie: the side that did not go last wins.
                    enter_s   = 1'b1;
                    enter_b_s = ~last_r;
                end else if (a_valid) begin
                    enter_s   = 1'b1;
                    enter_b_s = 1'b0;
                end else if (b_valid) begin
                    enter_s   = 1'b1;
                    enter_b_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end

            GRANT_A: begin
                out_valid_s = a_valid;
                a_ready_s   = out_ready && a_valid;
                if (!a_valid) begin
                    // Owner has nothing to offer: hand over or go idle.
                    if (b_valid) begin
                        enter_s   = 1'b1;
                        enter_b_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (out_ready) begin
                    if (count_r == HOLD_LAST) begin
                        // Burst limit reached on this beat.
                        if (b_valid) begin
                            enter_s   = 1'b1;
                            enter_b_s = 1'b1;
                        end else begin
                            count_s = '0;
                        end
                    end else begin
                        count_s = count_r + CW'(1);
                    end
                end else begin
                    // Word offered but not accepted: keep it, change nothing.
                    state_s = GRANT_A;
                end
            end

            GRANT_B: begin
                out_valid_s = b_valid;
                b_ready_s   = out_ready && b_valid;
                if (!b_valid) begin
                    if (a_valid) begin
                        enter_s   = 1'b1;
                        enter_b_s = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (out_ready) begin
                    if (count_r == HOLD_LAST) begin
                        if (a_valid) begin
                            enter_s   = 1'b1;
                            enter_b_s = 1'b0;
                        end else begin
                            count_s = '0;
                        end
                    end else begin
                        count_s = count_r + CW'(1);
                    end
                end else begin
                    state_s = GRANT_B;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase

        if (enter_s) begin
            state_s = enter_b_s ? GRANT_B : GRANT_A;
            sel_s   = enter_b_s;
            last_s  = enter_b_s;
            count_s = '0;
        end else begin
            enter_b_s = enter_b_s;
        end
    end

    // Handshake outputs follow the owner's valid and the sink's ready.
    assign out_valid = out_valid_s;
    assign a_ready   = a_ready_s;
    assign b_ready   = b_ready_s;

    // Select is a register; the data path is the plain 2:1 mux behind it.
    assign sel      = sel_r;
    assign out_data = sel_r ? b_data : a_data;
    assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: a turn-taking reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with
// occasional asynchronous resets.
module tb_mux_arbiter;

    localparam int WIDTH    = 16;
    localparam int MAX_HOLD = 4;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b1;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data  = '0;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data  = '0;
    logic             out_ready = 1'b0;
    logic             a_ready;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             sel;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = A, 2 = B. last: 1 = A, 2 = B. beats = beats taken in this turn.
    typedef struct packed {
        logic [1:0] owner;
        logic [3:0] beats;
        logic [1:0] last;
        logic       msel;
    } mstate_t;

    mstate_t m = '{owner: 2'd0, beats: 4'd0, last: 2'd2, msel: 1'b0};

    function automatic mstate_t give_turn(input logic [1:0] side);
        mstate_t n;
        n.owner = side;
        n.beats = 4'd0;
        n.last  = side;
        n.msel  = (side == 2'd2);
        return n;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic av, input logic bv, input logic rdy);
        logic       mine;
        logic       theirs;
        logic [1:0] other;
        if (s.owner == 2'd0) begin
            if (av && bv) return give_turn((s.last == 2'd1) ? 2'd2 : 2'd1);
            if (av) return give_turn(2'd1);
            if (bv) return give_turn(2'd2);
            return s;
        end
        mine   = (s.owner == 2'd1) ? av : bv;
        theirs = (s.owner == 2'd1) ? bv : av;
        other  = (s.owner == 2'd1) ? 2'd2 : 2'd1;
        if (!mine) begin
            if (theirs) return give_turn(other);
            s.owner = 2'd0;
            return s;
        end
        if (!rdy) return s;
        s.beats = s.beats + 4'd1;
        if (int'(s.beats) == MAX_HOLD) begin
            if (theirs) return give_turn(other);
            s.beats = 4'd0;
        end
        return s;
    endfunction

    // Model advances on each clock edge and collapses on async reset.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m <= '{owner: 2'd0, beats: 4'd0, last: 2'd2, msel: 1'b0};
        else          m <= step(m, a_valid, b_valid, out_ready);
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clock) begin
        logic exp_ov;
        exp_ov = (m.owner == 2'd1) ? a_valid : ((m.owner == 2'd2) ? b_valid : 1'b0);
        check("out_valid", out_valid, exp_ov);
        check("a_ready", a_ready, (m.owner == 2'd1) && a_valid && out_ready);
        check("b_ready", b_ready, (m.owner == 2'd2) && b_valid && out_ready);
        check("sel", sel, m.msel);
        check("busy", busy, m.owner != 2'd0);
        check("out_data", out_data, m.msel ? b_data : a_data);
    end

    // ---------------- beat log for literal expectations ----------------
    byte             side_q[$];
    logic [WIDTH-1:0] data_q[$];
    int              both_hi = 0;

    // Record each accepted beat and any overlap of the two readies.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            side_q.push_back(a_ready ? byte'("A") : (b_ready ? byte'("B") : byte'("?")));
            data_q.push_back(out_data);
        end
        if (a_ready && b_ready) both_hi++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        side_q.delete();
        data_q.delete();
        both_hi = 0;
    endtask

    task automatic do_reset();
        tick();
        reset_n   = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic check_seq(input string name, input string exp);
        check({name, "_len"}, side_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < side_q.size(); i++)
            check($sformatf("%s_%0d", name, i), 32'(side_q[i]), 32'(exp[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic took_a;
        logic took_b;

        // Reset state, with data visible through the A leg.
        #1 reset_n = 1'b0;
        a_data = 16'h1234;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sel", sel, 1'b0);
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_out_data", out_data, 16'h1234);
        do_reset();

        // Single source: six consecutive A beats, no switch.
        a_valid = 1'b1; a_data = 16'h0001; out_ready = 1'b1;
        @(negedge clock);
        check("ss_latency_ov", out_valid, 1'b0);
        tick();
        for (int i = 2; i <= 6; i++) begin
            tick();
            a_data = 16'(i);
        end
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        check_seq("ss_seq", "AAAAAA");
        for (int i = 0; i < 6 && i < data_q.size(); i++)
            check($sformatf("ss_data_%0d", i), data_q[i], 32'(i + 1));
        check("ss_sel", sel, 1'b0);

        // Contention: bursts of MAX_HOLD alternate with no bubble.
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        a_data = 16'hAAAA; b_data = 16'hBBBB;
        tick();
        repeat (12) tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        tick();
        check_seq("ct_seq", "AAAABBBBAAAA");
        check("ct_both_ready", both_hi, 0);

        // Backpressure: A's word is held across stalls, count preserved.
        do_reset();
        a_valid = 1'b1; a_data = 16'h00A5; out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0; b_valid = 1'b1; b_data = 16'h0B5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_sel", sel, 1'b0);
            check("bp_data", out_data, 16'h00A5);
            check("bp_a_ready", a_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        repeat (4) tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        check_seq("bp_seq", "AAAAB");
        if (data_q.size() > 1) check("bp_first_after_stall", data_q[1], 16'h00A5);
        else check("bp_first_after_stall_len", data_q.size(), 2);

        // Owner drops valid: one bubble, then B; next tie goes to A.
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        a_data = 16'h1111; b_data = 16'h2222;
        tick();
        tick();
        a_valid = 1'b0;
        @(negedge clock);
        check("od_bubble_ov", out_valid, 1'b0);
        check("od_bubble_busy", busy, 1'b1);
        tick();
        @(negedge clock);
        check("od_sel_b", sel, 1'b1);
        check("od_b_ready", b_ready, 1'b1);
        check("od_b_data", out_data, 16'h2222);
        tick();
        b_valid = 1'b0;
        tick();
        a_valid = 1'b1; b_valid = 1'b1;
        @(negedge clock);
        check("od_idle_busy", busy, 1'b0);
        tick();
        @(negedge clock);
        check("od_tie_sel", sel, 1'b0);
        check("od_tie_a_ready", a_ready, 1'b1);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // Idle return after a single B beat: select holds at B.
        do_reset();
        b_valid = 1'b1; b_data = 16'h0B0B; out_ready = 1'b1;
        tick();
        @(negedge clock);
        check("ir_b_ready", b_ready, 1'b1);
        check("ir_data", out_data, 16'h0B0B);
        tick();
        b_valid = 1'b0;
        tick();
        @(negedge clock);
        check("ir_busy", busy, 1'b0);
        check("ir_sel", sel, 1'b1);
        check("ir_out_valid", out_valid, 1'b0);

        // Reset in the middle of an A burst, then A wins the tie again.
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        tick();
        #1 reset_n = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_a_ready", a_ready, 1'b0);
        check("mr_b_ready", b_ready, 1'b0);
        check("mr_sel", sel, 1'b0);
        check("mr_busy", busy, 1'b0);
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("mr_idle_busy", busy, 1'b0);
        tick();
        @(negedge clock);
        check("mr_first_sel", sel, 1'b0);
        check("mr_first_a_ready", a_ready, 1'b1);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // Randomized traffic obeying hold-until-ready, with rare resets.
        took_a = 1'b0;
        took_b = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            took_a = a_ready;
            took_b = b_ready;
            tick();
            if (!a_valid || took_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_data  = 16'($urandom);
            end
            if (!b_valid || took_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_data  = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
